// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int MULDIV_W   = 32;
    localparam int MULDIV_LAT = MULDIV_W + 2;

    localparam logic [MULDIV_W-1:0] DIV_ZERO_Q = '1;
    localparam logic [MULDIV_W-1:0] OVF_Q      = {1'b1, {(MULDIV_W-1){1'b0}}};

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Radix-2 iterative RV32M multiply/divide: one product/quotient bit per cycle,
// sign-fixed in a final cycle, result handed to the register file with a done pulse.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int W      = 32,
    parameter int nu_reg = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [W-1:0]      operand_a_i,
    input  logic [W-1:0]      operand_b_i,
    input  logic [nu_reg-1:0] rd_addr_i,
    input  logic              kill_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [W-1:0]      result_o,
    output logic [nu_reg-1:0] rd_addr_o
);

    localparam int CNT_W = $clog2(W);

    // Valid/ready contract: start_i is taken only in IDLE/DONE with kill_i low;
    // done_o is a one-cycle strobe with result_o/rd_addr_o stable from then on.
    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]     p_q, p_d;
    logic [W-1:0]       m_q, m_d;
    logic               neg_q_q, neg_q_d;
    logic               neg_r_q, neg_r_d;
    logic [nu_reg-1:0]  rd_pend_q, rd_pend_d;
    logic [W-1:0]       result_q, result_d;
    logic [nu_reg-1:0]  rd_addr_q, rd_addr_d;

    op_e            op_in;
    logic           a_neg, b_neg, div_zero, div_ovf;
    logic [W-1:0]   a_abs, b_abs;
    logic [W:0]     mul_sum, div_tmp, div_diff;
    logic [2*W-1:0] prod_s;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        m_d       = m_q;
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
        rd_pend_d = rd_pend_q;
        result_d  = result_q;
        rd_addr_d = rd_addr_q;
        mul_sum   = '0;
        div_tmp   = '0;
        div_diff  = '0;
        prod_s    = '0;

        op_in    = op_e'(op_i);
        a_neg    = operand_a_i[W-1] && (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        b_neg    = operand_b_i[W-1] && (op_in inside {OP_MULH, OP_DIV, OP_REM});
        a_abs    = a_neg ? -operand_a_i : operand_a_i;
        b_abs    = b_neg ? -operand_b_i : operand_b_i;
        div_zero = op_i[2] && (operand_b_i == '0);
        div_ovf  = (op_in inside {OP_DIV, OP_REM}) && (operand_a_i == W'(OVF_Q))
                   && (operand_b_i == '1);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i && !kill_i) begin
                    op_d      = op_in;
                    rd_pend_d = rd_addr_i;
                    cnt_d     = '0;
                    neg_q_d   = a_neg ^ b_neg;
                    neg_r_d   = a_neg;
                    if (div_zero) begin
                        state_d   = ST_DONE;
                        result_d  = op_i[1] ? operand_a_i : W'(DIV_ZERO_Q);
                        rd_addr_d = rd_addr_i;
                    end else if (div_ovf) begin
                        state_d   = ST_DONE;
                        result_d  = op_i[1] ? '0 : W'(OVF_Q);
                        rd_addr_d = rd_addr_i;
                    end else begin
                        state_d = ST_CALC;
                        // Low half holds the multiplier (mul) or the dividend (div).
                        p_d     = {{W{1'b0}}, (op_i[2] ? a_abs : b_abs)};
                        m_d     = op_i[2] ? b_abs : a_abs;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (!op_q[2]) begin
                    mul_sum = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, m_q} : '0);
                    p_d     = {mul_sum, p_q[W-1:1]};
                end else begin
                    // High half is the partial remainder, low half the quotient.
                    div_tmp  = {p_q[2*W-1:W], p_q[W-1]};
                    div_diff = div_tmp - {1'b0, m_q};
                    if (!div_diff[W]) p_d = {div_diff[W-1:0], p_q[W-2:0], 1'b1};
                    else              p_d = {div_tmp[W-1:0],  p_q[W-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(W-1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                prod_s = neg_q_q ? -p_q : p_q;
                case (op_q)
                    OP_MUL:                       result_d = p_q[W-1:0];
                    OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_s[2*W-1:W];
                    OP_DIV, OP_DIVU:              result_d = neg_q_q ? -p_q[W-1:0] : p_q[W-1:0];
                    default:                      result_d = neg_r_q ? -p_q[2*W-1:W] : p_q[2*W-1:W];
                endcase
                rd_addr_d = rd_pend_q;
                state_d   = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (kill_i) begin
            state_d   = ST_IDLE;
            result_d  = result_q;
            rd_addr_d = rd_addr_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_MUL;
            cnt_q     <= '0;
            p_q       <= '0;
            m_q       <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            rd_pend_q <= '0;
            result_q  <= '0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            p_q       <= p_d;
            m_q       <= m_d;
            neg_q_q   <= neg_q_d;
            neg_r_q   <= neg_r_d;
            rd_pend_q <= rd_pend_d;
            result_q  <= result_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    assign busy_o    = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign done_o    = (state_q == ST_DONE);
    assign result_o  = result_q;
    assign rd_addr_o = rd_addr_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, scoreboard queue, and
// hand-written kill / reset / back-to-back sequences.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic [4:0]  rd_addr_i;
    logic        kill_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_addr_o;

    muldiv_unit #(.W(32), .nu_reg(5)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .op_i        (op_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .rd_addr_i   (rd_addr_i),
        .kill_i      (kill_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .result_o    (result_o),
        .rd_addr_o   (rd_addr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        op_e         op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    logic [4:0]  exp_rd_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_res = '0;
    logic [4:0]  last_rd  = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input op_e op, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] rd,
                                input logic [31:0] exp, input int lat);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.rd = rd; v.exp = exp; v.lat = lat;
        return v;
    endfunction

    // Called at a negedge while the unit is IDLE or DONE; returns at the
    // negedge of the done cycle so the next call issues back-to-back.
    task automatic run_op(input string name, input op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int lat);
        int c;
        bit seen;
        logic [31:0] e_res;
        logic [4:0]  e_rd;
        exp_q.push_back(exp);
        exp_rd_q.push_back(rd);
        start_i = 1'b1; op_i = op; operand_a_i = a; operand_b_i = b; rd_addr_i = rd;
        seen = 1'b0;
        for (c = 1; c <= 60 && !seen; c++) begin
            @(negedge clk_i);
            start_i     = 1'b0;
            operand_a_i = $urandom;
            operand_b_i = $urandom;
            rd_addr_i   = 5'($urandom_range(0, 31));
            if (done_o) begin
                seen  = 1'b1;
                e_res = exp_q.pop_front();
                e_rd  = exp_rd_q.pop_front();
                check({name, " latency"}, 32'(c), 32'(lat));
                check({name, " result"}, result_o, e_res);
                check({name, " rd"}, 32'(rd_addr_o), 32'(e_rd));
                check({name, " busy at done"}, 32'(busy_o), 32'd0);
                last_res = e_res;
                last_rd  = e_rd;
            end else if (c == 1 || c == lat - 1) begin
                check({name, " busy"}, 32'(busy_o), 32'(lat > 1));
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: no done_o within 60 cycles, expected at cycle %0d", name, lat);
            void'(exp_q.pop_front());
            void'(exp_rd_q.pop_front());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic [63:0] prod;
        logic [31:0] prev_res;
        logic [4:0]  prev_rd;
        bit          got_done;

        rst_ni = 1'b0; start_i = 1'b0; kill_i = 1'b0; op_i = '0;
        operand_a_i = '0; operand_b_i = '0; rd_addr_i = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset done", 32'(done_o), 32'd0);
        check("reset result", result_o, 32'd0);
        check("reset rd", 32'(rd_addr_o), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        vecs.push_back(mk("mul_neg",      OP_MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 34));
        vecs.push_back(mk("mulh_min",     OP_MULH,   32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 34));
        vecs.push_back(mk("mulhu_max",    OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 34));
        vecs.push_back(mk("mulhsu_m1",    OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 34));
        vecs.push_back(mk("mulh_m1m1",    OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,  32'h00000000, 34));
        vecs.push_back(mk("mulhu_carry",  OP_MULHU,  32'h80000000, 32'd2,        5'd10, 32'h00000001, 34));
        vecs.push_back(mk("div_neg",      OP_DIV,    32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFD, 34));
        vecs.push_back(mk("rem_neg",      OP_REM,    32'hFFFFFFF9, 32'd2,        5'd12, 32'hFFFFFFFF, 34));
        vecs.push_back(mk("div_negb",     OP_DIV,    32'd7,        32'hFFFFFFFE, 5'd13, 32'hFFFFFFFD, 34));
        vecs.push_back(mk("rem_negb",     OP_REM,    32'd7,        32'hFFFFFFFE, 5'd14, 32'h00000001, 34));
        vecs.push_back(mk("divu",         OP_DIVU,   32'd100,      32'd7,        5'd15, 32'd14,        34));
        vecs.push_back(mk("remu",         OP_REMU,   32'd100,      32'd7,        5'd16, 32'd2,         34));
        vecs.push_back(mk("divu_max",     OP_DIVU,   32'hFFFFFFFF, 32'd1,        5'd17, 32'hFFFFFFFF, 34));
        vecs.push_back(mk("div_zero",     OP_DIV,    32'd5,        32'd0,        5'd18, 32'hFFFFFFFF, 1));
        vecs.push_back(mk("remu_zero",    OP_REMU,   32'd5,        32'd0,        5'd19, 32'd5,         1));
        vecs.push_back(mk("rem_zero",     OP_REM,    32'hFFFFFFF0, 32'd0,        5'd20, 32'hFFFFFFF0, 1));
        vecs.push_back(mk("divu_zero",    OP_DIVU,   32'd0,        32'd0,        5'd0,  32'hFFFFFFFF, 1));
        vecs.push_back(mk("div_ovf",      OP_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd21, 32'h80000000, 1));
        vecs.push_back(mk("rem_ovf",      OP_REM,    32'h80000000, 32'hFFFFFFFF, 5'd22, 32'h00000000, 1));
        vecs.push_back(mk("rd_zero",      OP_MUL,    32'd6,        32'd7,        5'd0,  32'd42,        34));
        for (int i = 0; i < 3; i++) begin
            ra   = $urandom;
            rb   = 32'($urandom_range(1, 100000));
            prod = {32'd0, ra} * {32'd0, rb};
            vecs.push_back(mk("rand_divu",  OP_DIVU,  ra, rb, 5'd23, ra / rb, 34));
            vecs.push_back(mk("rand_remu",  OP_REMU,  ra, rb, 5'd24, ra % rb, 34));
            vecs.push_back(mk("rand_mulhu", OP_MULHU, ra, rb, 5'd25, prod[63:32], 34));
            vecs.push_back(mk("rand_mul",   OP_MUL,   ra, rb, 5'd26, prod[31:0], 34));
        end

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat);

        // Kill in DONE together with start: done already showing, start refused.
        start_i = 1'b1; kill_i = 1'b1; op_i = OP_DIVU; operand_a_i = 32'd9; operand_b_i = 32'd3;
        @(negedge clk_i);
        start_i = 1'b0; kill_i = 1'b0;
        check("kill_start busy", 32'(busy_o), 32'd0);
        check("kill_start done", 32'(done_o), 32'd0);
        @(negedge clk_i);
        check("kill_start idle done", 32'(done_o), 32'd0);

        // Kill mid-DIVU with ignored starts while busy, then restart at cycle 12.
        prev_res = last_res;
        prev_rd  = last_rd;
        got_done = 1'b0;
        start_i = 1'b1; op_i = OP_DIVU; operand_a_i = 32'd1000; operand_b_i = 32'd3; rd_addr_i = 5'd11;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            kill_i  = 1'b0;
            if (done_o) got_done = 1'b1;
            if (c == 3 || c == 5) begin
                start_i = 1'b1; op_i = OP_MUL; rd_addr_i = 5'd30;
                operand_a_i = $urandom; operand_b_i = $urandom;
            end
            if (c == 10) begin
                check("kill busy before", 32'(busy_o), 32'd1);
                kill_i = 1'b1;
            end
        end
        check("kill no done", 32'(got_done), 32'd0);
        check("kill busy after", 32'(busy_o), 32'd0);
        check("kill result held", result_o, prev_res);
        check("kill rd held", 32'(rd_addr_o), 32'(prev_rd));
        @(negedge clk_i);
        run_op("kill_restart", OP_DIVU, 32'd100, 32'd7, 5'd9, 32'd14, 34);

        // Asynchronous reset at cycle 20 of a MUL.
        start_i = 1'b1; op_i = OP_MUL; operand_a_i = 32'd12345; operand_b_i = 32'd678; rd_addr_i = 5'd4;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk_i);
            start_i = 1'b0;
        end
        #1;
        rst_ni = 1'b0;
        #1;
        check("async rst busy", 32'(busy_o), 32'd0);
        check("async rst done", 32'(done_o), 32'd0);
        check("async rst result", result_o, 32'd0);
        check("async rst rd", 32'(rd_addr_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("post rst idle busy", 32'(busy_o), 32'd0);
        check("post rst idle done", 32'(done_o), 32'd0);
        run_op("post_rst_mul", OP_MUL, 32'd3, 32'd4, 5'd2, 32'd12, 34);

        check("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage.
- Consumes the two register-file read operands (rs1/rs2 data) plus rd address.
- Produces a 32-bit result with a one-cycle write strobe that drives register-file write data, address and enable directly.
- Radix-2, one bit per cycle; multi-cycle, with a start/busy/done handshake and a flush input.

Parameters:
W, 32, operand/result width (only 32 is verified)
nu_reg, 5, register address width
CNT_W, $clog2(W), iteration counter width (derived, not overridable)

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
start_i  input  1  request; accepted when state is IDLE or DONE
op_i  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
operand_a_i  input  W  rs1 value
operand_b_i  input  W  rs2 value
rd_addr_i  input  nu_reg  destination register
kill_i  input  1  pipeline flush; aborts current operation
busy_o  output  1  high in CALC and FIX
done_o  output  1  one-cycle result-valid pulse; feeds register-file wr_en
result_o  output  W  result; held stable until the next done_o
rd_addr_o  output  nu_reg  rd captured at accept; held with result_o

Behaviour:
- Reset (async, rst_ni low): state IDLE; busy_o=0, done_o=0, result_o=0, rd_addr_o=0; counter and accumulators cleared. Applies immediately, including mid-CALC.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE/DONE + start_i=1 + kill_i=0: latch op, operands and rd; compute abs values for signed ops; record result-sign flags.
  - Special case (DIV/DIVU/REM/REMU with b=0, or DIV/REM with a=0x80000000 and b=0xFFFFFFFF): go to DONE directly.
  - Otherwise: go to CALC with counter=0.
- IDLE/DONE with no accepted start: go to IDLE.
- CALC, multiply: shift-add of unsigned magnitudes into a 2W-bit product.
- CALC, divide: restoring shift-subtract producing W-bit quotient and remainder.
- CALC: counter increments each cycle. After exactly W iterations (counter==W-1) go to FIX.
- FIX: apply sign correction and select the result into result_o. Go to DONE.
  - MUL: low W bits. MULH/MULHSU/MULHU: high W bits.
  - DIV/DIVU: quotient. REM/REMU: remainder.
- DONE: done_o=1 for exactly this cycle; next state per the IDLE/DONE rule (back-to-back ops allowed).
- Signedness:
  - MULH: a and b signed.
  - MULHSU: a signed, b unsigned.
  - MULHU and MUL magnitude path: unsigned.
  - DIV/REM: signed; quotient sign = sign(a) xor sign(b); remainder takes the sign of a.
- Latency: accept cycle = cycle 0. Normal op: CALC cycles 1..W, FIX cycle W+1, done_o in cycle W+2 (34).
- Special cases: done_o in cycle 1.
  - Divide by zero: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = a.
  - Overflow: DIV result 0x80000000; REM result 0.
- busy_o=1 in CALC and FIX: start_i is ignored; operand inputs may change freely.
- kill_i=1 (any state): next state IDLE; no done_o for the in-flight op; result_o/rd_addr_o keep their last values.
  - kill_i and start_i together: kill wins; the start is not accepted.
  - kill_i in DONE: done_o still high in that cycle (already committed); next state IDLE.
- rd=0 is not special-cased: done_o pulses; the register file discards the write to x0.

Decomposition:
- Package muldiv_pkg holds: op enum (funct3 encoding above), state enum, MULDIV_LAT = W+2, and the DIV_ZERO_Q and OVF_Q constants.
- Single module. Datapath and FSM are small enough that no sub-module is warranted.

Test Plan:
- MUL a=7, b=0xFFFFFFFD, rd=5 at cycle 0 -> busy_o cycles 1..33; done_o only in cycle 34; result_o=0xFFFFFFEB; rd_addr_o=5.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF with done_o in cycle 1; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- kill_i at cycle 10 of a DIVU -> busy_o=0 from cycle 11, no done_o, result_o unchanged; start_i pulses during busy ignored; new start at cycle 12 -> done_o at cycle 46.
- rst_ni low at cycle 20 of a MUL -> busy_o, done_o, result_o, rd_addr_o read 0 immediately (before the next edge); after release, state IDLE; a fresh MUL 3*4 -> result_o=12.
